mat_reg_drain: RTL

MAT_REG_DRAIN -- requirements
Module: mat_reg_drain

---
 rtl/mat_reg_drain_if.sv | 40 ++++
 rtl/mat_reg_drain.sv | 80 ++++++++
 2 files changed

// File: rtl/mat_reg_drain_if.sv
// rtl/mat_reg_drain_if.sv - command, matrix-register read and output beat signals of the drain
// Slice elements carry IEEE-754 single-precision bit patterns, one 32-bit word per element.
typedef enum logic [1:0] {
  READ_DISABLE = 2'd0,
  READ_ROW     = 2'd1,
  READ_COL     = 2'd2,
  READ_DIAG    = 2'd3
} MatDataReadOp_t;

interface mat_reg_drain_if #(
  parameter int WIDTH           = 128,
  parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH)
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  MatDataReadOp_t                cmd_mode;
  logic [WIDTH_ADDR_SIZE-1:0]    cmd_start;
  logic [WIDTH_ADDR_SIZE:0]      cmd_count;

  MatDataReadOp_t                read_op;
  logic [WIDTH_ADDR_SIZE-1:0]    read_param;
  logic [WIDTH-1:0][31:0]        reg_data;

  logic                          out_valid;
  logic                          out_ready;
  logic [WIDTH-1:0][31:0]        out_data;
  logic [WIDTH_ADDR_SIZE-1:0]    out_index;
  logic                          out_last;
  logic                          busy;

  modport master (
    input  cmd_valid, cmd_mode, cmd_start, cmd_count, reg_data, out_ready,
    output cmd_ready, read_op, read_param, out_valid, out_data, out_index, out_last, busy
  );

  modport slave (
    output cmd_valid, cmd_mode, cmd_start, cmd_count, reg_data, out_ready,
    input  cmd_ready, read_op, read_param, out_valid, out_data, out_index, out_last, busy
  );
endinterface

// File: rtl/mat_reg_drain.sv
// rtl/mat_reg_drain.sv - streams a run of row/column/diagonal slices out of a matrix register
// One beat per cycle; the read index is held whenever the output register is stalled.
module mat_reg_drain #(
  parameter int WIDTH           = 128,
  parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH)
) (
  input logic             clock,
  input logic             reset,
  mat_reg_drain_if.master bus
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                     state_q, state_d;
  MatDataReadOp_t             mode_q;
  logic [WIDTH_ADDR_SIZE-1:0] ptr_q, ptr_next;
  logic [WIDTH_ADDR_SIZE:0]   remaining_q;
  logic                       out_valid_q, out_last_q;
  logic [WIDTH_ADDR_SIZE-1:0] out_index_q;
  logic [WIDTH-1:0][31:0]     out_data_q;
  logic                       accept, capture, drained;

  // Empty or disabled commands are consumed in IDLE without leaving it.
  assign accept   = (state_q == IDLE) && bus.cmd_valid
                    && (bus.cmd_count != '0) && (bus.cmd_mode != READ_DISABLE);
  assign capture  = (state_q == STREAM) && (!out_valid_q || bus.out_ready);
  assign drained  = (state_q == FLUSH) && out_valid_q && bus.out_ready;
  assign ptr_next = (ptr_q == WIDTH_ADDR_SIZE'(WIDTH - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = STREAM;
      STREAM:  if (capture && (remaining_q == (WIDTH_ADDR_SIZE+1)'(1))) state_d = FLUSH;
      FLUSH:   if (drained) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= READ_DISABLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q      <= bus.cmd_mode;
        ptr_q       <= bus.cmd_start;
        remaining_q <= bus.cmd_count;
      end
      if (capture) begin
        out_data_q  <= bus.reg_data;
        out_index_q <= ptr_q;
        out_valid_q <= 1'b1;
        out_last_q  <= (remaining_q == (WIDTH_ADDR_SIZE+1)'(1));
        remaining_q <= remaining_q - 1'b1;
        ptr_q       <= ptr_next;
      end else if (drained) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.read_op    = (state_q == STREAM) ? mode_q : READ_DISABLE;
  assign bus.read_param = (state_q == STREAM) ? ptr_q : '0;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_index  = out_index_q;
  assign bus.out_data   = out_data_q;

endmodule
